// File: rtl/sdram_cmd_queue_pkg.sv
// Shared definitions for the sdram command queue: default widths, issue FSM encoding
// and the packed command-entry width.
package sdram_cmd_queue_pkg;

    localparam int SDRAM_AW = 23;
    localparam int SDRAM_DW = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Entry layout is {wr, addr, data}.
    function automatic int entry_width(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/sdram_cmd_queue_if.sv
// Bus bundle for the sdram command queue: upstream command/response side and the
// sdram controller req/ack side.
interface sdram_cmd_queue_if
    import sdram_cmd_queue_pkg::*;
#(
    parameter int AW = SDRAM_AW,
    parameter int DW = SDRAM_DW
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wr_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          sd_req;
    logic          sd_ack;
    logic          sd_wr;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_wr_data;
    logic          sd_rd_ack;
    logic [DW-1:0] sd_rd_data;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wr_data, sd_ack, sd_rd_ack, sd_rd_data,
        output cmd_ready, rsp_valid, rsp_data, sd_req, sd_wr, sd_addr, sd_wr_data
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wr_data, sd_ack, sd_rd_ack, sd_rd_data,
        input  cmd_ready, rsp_valid, rsp_data, sd_req, sd_wr, sd_addr, sd_wr_data
    );
endinterface

// File: rtl/sdram_cmd_queue_fifo.sv
// Synchronous command FIFO with full/empty flags; head entry is read straight from the
// storage registers.
module sdram_cmd_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 88
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// Command queue in front of the sdram controller: buffers requests, issues them one at a
// time on sd_req/sd_ack, limits outstanding reads. Optional counters: SDRAM_CMD_QUEUE_STATS_EN.
module sdram_cmd_queue
    import sdram_cmd_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 4,
    parameter int AW     = SDRAM_AW,
    parameter int DW     = SDRAM_DW
) (
    input  logic               clk,
    input  logic               reset_l,
    sdram_cmd_queue_if.slave   bus,
    output logic               busy
`ifdef SDRAM_CMD_QUEUE_STATS_EN
    ,
    output logic [31:0]        stat_wr,
    output logic [31:0]        stat_rd,
    output logic [31:0]        stat_stall
`endif
);
    localparam int         EW       = entry_width(AW, DW);
    localparam logic [3:0] MAX_RD_C = 4'(MAX_RD);

    state_e        state_q, state_d;
    logic          sd_req_q, sd_req_d;
    logic          sd_wr_q, sd_wr_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [DW-1:0] sd_data_q, sd_data_d;
    logic [3:0]    rd_cnt_q, rd_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          ready_en_q;

    logic [EW-1:0] head;
    logic          fifo_full, fifo_empty, push, pop;
    logic          head_wr, rd_limit, rd_inc, rd_dec;

    // cmd_ready comes only from registers, so there is no path from cmd_valid.
    assign bus.cmd_ready = ready_en_q && !fifo_full;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    sdram_cmd_queue_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push_i  (push),
        .din_i   ({bus.cmd_wr, bus.cmd_addr, bus.cmd_wr_data}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_wr  = head[EW-1];
    assign rd_limit = (rd_cnt_q >= MAX_RD_C);
    assign rd_inc   = (state_q == ST_REQ) && bus.sd_ack && !sd_wr_q;
    assign rd_dec   = bus.sd_rd_ack && (rd_cnt_q != 4'd0);

    always_comb begin
        state_d   = state_q;
        sd_req_d  = sd_req_q;
        sd_wr_d   = sd_wr_q;
        sd_addr_d = sd_addr_q;
        sd_data_d = sd_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Strict order: a blocked read head also holds back writes behind it.
                if (!fifo_empty && (head_wr || !rd_limit)) begin
                    pop       = 1'b1;
                    sd_req_d  = 1'b1;
                    sd_wr_d   = head_wr;
                    sd_addr_d = head[DW+AW-1:DW];
                    sd_data_d = head[DW-1:0];
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sd_ack) begin
                    sd_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !rd_dec)      rd_cnt_d = rd_cnt_q + 4'd1;
        else if (rd_dec && !rd_inc) rd_cnt_d = rd_cnt_q - 4'd1;
        rsp_valid_d = rd_dec;
        rsp_data_d  = rd_dec ? bus.sd_rd_data : rsp_data_q;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            sd_req_q    <= 1'b0;
            sd_wr_q     <= 1'b0;
            sd_addr_q   <= '0;
            sd_data_q   <= '0;
            rd_cnt_q    <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sd_req_q    <= sd_req_d;
            sd_wr_q     <= sd_wr_d;
            sd_addr_q   <= sd_addr_d;
            sd_data_q   <= sd_data_d;
            rd_cnt_q    <= rd_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign bus.sd_req     = sd_req_q;
    assign bus.sd_wr      = sd_wr_q;
    assign bus.sd_addr    = sd_addr_q;
    assign bus.sd_wr_data = sd_data_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign busy           = !fifo_empty || sd_req_q || (rd_cnt_q != 4'd0);

`ifdef SDRAM_CMD_QUEUE_STATS_EN
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic        wr_done, stall_cyc;

    assign wr_done   = (state_q == ST_REQ) && bus.sd_ack && sd_wr_q;
    assign stall_cyc = (state_q == ST_IDLE) && !fifo_empty && !head_wr && rd_limit;

    // Saturating counters.
    always_comb begin
        stat_wr_d    = (wr_done && !(&stat_wr_q)) ? stat_wr_q + 32'd1 : stat_wr_q;
        stat_rd_d    = (rd_inc && !(&stat_rd_q)) ? stat_rd_q + 32'd1 : stat_rd_q;
        stat_stall_d = (stall_cyc && !(&stat_stall_q)) ? stat_stall_q + 32'd1 : stat_stall_q;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stat_wr_q    <= '0;
            stat_rd_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_wr_q    <= stat_wr_d;
            stat_rd_q    <= stat_rd_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_wr    = stat_wr_q;
    assign stat_rd    = stat_rd_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Self-checking bench for sdram_cmd_queue: issue-order and response scoreboards, a vector
// table for mixed traffic, hand sequences for fill, read limit and reset corners.
module tb_sdram_cmd_queue;
    import sdram_cmd_queue_pkg::*;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    logic busy;
    always #4 clk = ~clk;

    sdram_cmd_queue_if bus ();

`ifdef SDRAM_CMD_QUEUE_STATS_EN
    logic [31:0] stat_wr, stat_rd, stat_stall;
    int          n_wr_acc = 0;
    int          n_rd_acc = 0;
`endif

    sdram_cmd_queue #(.DEPTH(4), .MAX_RD(4)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus),
        .busy    (busy)
`ifdef SDRAM_CMD_QUEUE_STATS_EN
        ,
        .stat_wr    (stat_wr),
        .stat_rd    (stat_rd),
        .stat_stall (stat_stall)
`endif
    );

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [63:0] data;
    } sd_t;

    typedef struct {
        logic        wr;
        logic [22:0] addr;
        logic [63:0] data;
        logic [63:0] rdat;
        logic [63:0] exp_rsp;
    } vec_t;

    sd_t         exp_sd[$];
    logic [63:0] exp_rsp[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          mdl_rd = 0;
    bit          rsp_pend = 1'b0;

    function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event occurred with no expectation queued", name);
    endfunction

    // Scoreboard sampling at the falling edge, between bench drive points.
    task automatic monitor();
        bit inc, dec;
        if (!reset_l) begin
            mdl_rd   = 0;
            rsp_pend = 1'b0;
            return;
        end
        if (rsp_pend || bus.rsp_valid) begin
            chk("rsp_valid", 96'(bus.rsp_valid), 96'(rsp_pend));
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) flag("rsp_unexpected");
                else chk("rsp_data", 96'(bus.rsp_data), 96'(exp_rsp.pop_front()));
            end
        end
        dec      = bus.sd_rd_ack && (mdl_rd > 0);
        rsp_pend = dec;
        inc      = 1'b0;
        if (bus.sd_req && bus.sd_ack) begin
            if (exp_sd.size() == 0) flag("sd_unexpected");
            else chk("sd_cmd", 96'({bus.sd_wr, bus.sd_addr, bus.sd_wr_data}), 96'(exp_sd.pop_front()));
            inc = !bus.sd_wr;
`ifdef SDRAM_CMD_QUEUE_STATS_EN
            if (bus.sd_wr) n_wr_acc++;
            else n_rd_acc++;
`endif
        end
        if (inc && !dec) mdl_rd++;
        else if (dec && !inc) mdl_rd--;
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_try(input logic wr, input logic [22:0] addr, input logic [63:0] data, output bit acc);
        bus.cmd_valid   = 1'b1;
        bus.cmd_wr      = wr;
        bus.cmd_addr    = addr;
        bus.cmd_wr_data = data;
        acc = bus.cmd_ready;
        if (acc) exp_sd.push_back({wr, addr, data});
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push(input logic wr, input logic [22:0] addr, input logic [63:0] data);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) push_try(wr, addr, data, acc);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for addr 0x%0h", addr);
        end
    endtask

    task automatic ack_one();
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.sd_req) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL sd_req_timeout: sd_req never rose, required 1");
        end else begin
            bus.sd_ack = 1'b1;
            cyc();
            bus.sd_ack = 1'b0;
        end
    endtask

    task automatic rd_ack(input logic [63:0] drv, input logic [63:0] expv);
        if (mdl_rd > 0) exp_rsp.push_back(expv);
        bus.sd_rd_ack  = 1'b1;
        bus.sd_rd_data = drv;
        cyc();
        bus.sd_rd_ack = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   acc;
        int   highs;

        vecs[0] = '{1'b1, 23'h000005, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0};
        vecs[1] = '{1'b0, 23'h000005, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
        vecs[2] = '{1'b1, 23'h000006, 64'hFEDC_BA98_7654_3210, 64'h0, 64'h0};
        vecs[3] = '{1'b0, 23'h7FFFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{1'b1, 23'h000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        vecs[5] = '{1'b0, 23'h000000, 64'h0, 64'h5A5A_0000_1234_0000, 64'h5A5A_0000_1234_0000};

        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_wr_data = '0;
        bus.sd_ack = 1'b0; bus.sd_rd_ack = 1'b0; bus.sd_rd_data = '0;

        // Reset values
        cyc(); cyc();
        chk("rst_cmd_ready", 96'(bus.cmd_ready), 96'(0));
        chk("rst_sd_req", 96'(bus.sd_req), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_rsp_valid", 96'(bus.rsp_valid), 96'(0));
        chk("rst_sd_bus", 96'({bus.sd_wr, bus.sd_addr, bus.sd_wr_data}), 96'(0));
        reset_l = 1'b1;
        cyc();
        chk("ready_after_rst", 96'(bus.cmd_ready), 96'(1));

        // Single write: issue latency and release after ack
        push(1'b1, 23'h000010, 64'h1122_3344_5566_7788);
        chk("wr1_req_lat1", 96'(bus.sd_req), 96'(0));
        chk("wr1_busy", 96'(busy), 96'(1));
        cyc();
        chk("wr1_req_lat2", 96'(bus.sd_req), 96'(1));
        chk("wr1_sd_bus", 96'({bus.sd_wr, bus.sd_addr, bus.sd_wr_data}),
            96'({1'b1, 23'h000010, 64'h1122_3344_5566_7788}));
        ack_one();
        chk("wr1_req_drop", 96'(bus.sd_req), 96'(0));
        chk("wr1_busy_end", 96'(busy), 96'(0));

        // Vector table in groups of three: order, read data return
        for (int g = 0; g < 6; g += 3) begin
            for (int i = g; i < g + 3; i++) push(vecs[i].wr, vecs[i].addr, vecs[i].data);
            for (int i = g; i < g + 3; i++) ack_one();
            for (int i = g; i < g + 3; i++)
                if (!vecs[i].wr) rd_ack(vecs[i].rdat, vecs[i].exp_rsp);
            cyc();
            chk("vec_busy_end", 96'(busy), 96'(0));
        end

        // Fill: five accepted with sd_ack held low, then refused
        for (int i = 0; i < 5; i++) begin
            push_try(1'b1, 23'(32'h200 + i), 64'(32'hC0DE_0000 + i), acc);
            chk("fill_accept", 96'(acc), 96'(1));
        end
        chk("fill_full", 96'(bus.cmd_ready), 96'(0));
        push_try(1'b1, 23'h0002FF, 64'h0, acc);
        chk("fill_refuse", 96'(acc), 96'(0));
        ack_one();
        push_try(1'b1, 23'h0002FE, 64'h0, acc);
        chk("full_pop_push", 96'(acc), 96'(0));
        chk("ready_after_pop", 96'(bus.cmd_ready), 96'(1));
        for (int i = 0; i < 4; i++) ack_one();
        chk("fill_busy_end", 96'(busy), 96'(0));

        // Read limit
        for (int i = 0; i < 4; i++) push(1'b0, 23'(32'h100 + i), 64'h0);
        for (int i = 0; i < 4; i++) ack_one();
        push(1'b0, 23'h000104, 64'h0);
        push(1'b0, 23'h000105, 64'h0);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.sd_req) highs++;
            cyc();
        end
        chk("rdlim_stall", 96'(highs), 96'(0));
        chk("rdlim_busy", 96'(busy), 96'(1));
        rd_ack(64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("rdlim_release_lat1", 96'(bus.sd_req), 96'(0));
        cyc();
        chk("rdlim_release_lat2", 96'(bus.sd_req), 96'(1));
        chk("rdlim_5th_addr", 96'(bus.sd_addr), 96'(23'h000104));
        ack_one();
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.sd_req) highs++;
            cyc();
        end
        chk("rdlim_6th_stall", 96'(highs), 96'(0));
        rd_ack(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
        cyc();
        chk("rdlim_6th_req", 96'(bus.sd_req), 96'(1));
        rd_ack(64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888);

        // Simultaneous read ack and read data at two outstanding
        chk("simul_pre_cnt", 96'(dut.rd_cnt_q), 96'(2));
        exp_rsp.push_back(64'h9999_AAAA_BBBB_CCCC);
        bus.sd_ack = 1'b1; bus.sd_rd_ack = 1'b1; bus.sd_rd_data = 64'h9999_AAAA_BBBB_CCCC;
        cyc();
        bus.sd_ack = 1'b0; bus.sd_rd_ack = 1'b0;
        chk("simul_rd_cnt", 96'(dut.rd_cnt_q), 96'(2));
        rd_ack(64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F);
        rd_ack(64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0);
        cyc();
        chk("rdlim_busy_end", 96'(busy), 96'(0));

        // Read data with nothing outstanding is dropped
        rd_ack(64'hBAD0_BAD0_BAD0_BAD0, 64'h0);
        cyc();
        chk("proto_err_cnt", 96'(dut.rd_cnt_q), 96'(0));
        chk("proto_err_rsp", 96'(bus.rsp_valid), 96'(0));
        chk("proto_err_busy", 96'(busy), 96'(0));

`ifdef SDRAM_CMD_QUEUE_STATS_EN
        chk("stat_wr", 96'(stat_wr), 96'(n_wr_acc));
        chk("stat_rd", 96'(stat_rd), 96'(n_rd_acc));
        chk("stat_stall_seen", 96'(stat_stall != 32'd0), 96'(1));
`endif

        // Asynchronous reset while a request is pending
        push(1'b1, 23'h000ABC, 64'hCAFE_F00D_CAFE_F00D);
        cyc();
        chk("mid_req_up", 96'(bus.sd_req), 96'(1));
        @(posedge clk);
        #3;
        reset_l = 1'b0;
        #1;
        chk("arst_sd_req", 96'(bus.sd_req), 96'(0));
        chk("arst_busy", 96'(busy), 96'(0));
        chk("arst_cmd_ready", 96'(bus.cmd_ready), 96'(0));
        chk("arst_sd_bus", 96'({bus.sd_wr, bus.sd_addr, bus.sd_wr_data}), 96'(0));
        chk("arst_rsp", 96'({bus.rsp_valid, bus.rsp_data}), 96'(0));
`ifdef SDRAM_CMD_QUEUE_STATS_EN
        chk("arst_stats", 96'({stat_wr, stat_rd, stat_stall}), 96'(0));
`endif
        exp_sd.delete();
        exp_rsp.delete();
        @(posedge clk);
        #1;
        cyc();
        reset_l = 1'b1;
        cyc();
        cyc();
        chk("post_rst_ready", 96'(bus.cmd_ready), 96'(1));
        push(1'b1, 23'h000077, 64'h7777_0000_7777_0000);
        ack_one();
        cyc();
        chk("post_rst_busy", 96'(busy), 96'(0));
        chk("sb_empty", 96'(exp_sd.size() + exp_rsp.size()), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
